// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles little-endian 32-bit words from pin strobes and writes instruction memory.
// Optional running byte checksum enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W      = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              strobe,
   input  logic [7:0]        data_in,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic [ADDR_W:0]   word_count,
   output logic              err_partial,
   output logic              err_overflow,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] load_sync;
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic                   load_prev;
   logic                   strobe_prev;
   logic [1:0]             byte_idx;
   logic [23:0]            asm_q;
   logic                   we_q;

   logic load_s;
   logic strobe_s;
   logic load_rise;
   logic strobe_edge;
   logic capture;

   assign load_s      = load_sync[SYNC_STAGES-1];
   assign strobe_s    = strobe_sync[SYNC_STAGES-1];
   assign load_rise   = load_s & ~load_prev;
   assign strobe_edge = strobe_s & ~strobe_prev;
   // A strobe edge that coincides with load_en dropping is not a capture.
   assign capture     = strobe_edge & load_s & (state != S_IDLE);

   // Gate with rst so no write can escape on the cycle reset is applied.
   assign imem_we = we_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         load_sync    <= '0;
         strobe_sync  <= '0;
         load_prev    <= 1'b0;
         strobe_prev  <= 1'b0;
         byte_idx     <= 2'd0;
         asm_q        <= '0;
         we_q         <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b0;
         busy         <= 1'b0;
         word_count   <= '0;
         err_partial  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         load_sync   <= {load_sync[SYNC_STAGES-2:0], load_en};
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], strobe};
         load_prev   <= load_s;
         strobe_prev <= strobe_s;
         we_q        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_rise) begin
                  state        <= S_LOAD;
                  cpu_hold     <= 1'b1;
                  busy         <= 1'b1;
                  imem_addr    <= '0;
                  word_count   <= '0;
                  byte_idx     <= 2'd0;
                  err_partial  <= 1'b0;
                  err_overflow <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!load_s) begin
                  if (byte_idx != 2'd0) err_partial <= 1'b1;
                  byte_idx <= 2'd0;
                  state    <= S_IDLE;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end else if (capture) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_q[7:0]   <= data_in;
                     2'd1: asm_q[15:8]  <= data_in;
                     2'd2: asm_q[23:16] <= data_in;
                     default: begin
                        state      <= S_WRITE;
                        imem_wdata <= {data_in, asm_q};
                        // Memory already full: drop the word and flag it.
                        if (word_count[ADDR_W]) err_overflow <= 1'b1;
                        else                    we_q         <= 1'b1;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               if (we_q) begin
                  imem_addr  <= imem_addr + 1'b1;
                  word_count <= word_count + 1'b1;
               end
               if (!load_s) begin
                  state    <= S_IDLE;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end else begin
                  state <= S_LOAD;
                  if (capture) begin
                     asm_q[7:0] <= data_in;
                     byte_idx   <= 2'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst)                              checksum <= 8'h00;
      else if (state == S_IDLE && load_rise) checksum <= 8'h00;
      else if (capture)                      checksum <= checksum + data_in;
   end
`else
   assign checksum = 8'h00;
`endif

endmodule
